// File: rtl/btn_evt_pkg.sv
// Shared constants and types for the pushbutton event arbiter.
package btn_evt_pkg;

  localparam int FILT_LEN  = 4;
  localparam int REP_FIRST = 50;
  localparam int REP_NEXT  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/btn_filter.sv
// One button: 2-flop synchroniser, 4-sample hysteresis filter, press pulse.
// AUTO_REPEAT_EN adds a hold counter that re-fires the press pulse while held.
module btn_filter
  import btn_evt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic pb_i,
  output logic level_o,
  output logic evt_o
);

  logic                sync1_q, sync2_q;
  logic [FILT_LEN-1:0] shreg_q;
  logic [FILT_LEN-1:0] shreg_d;
  logic                level_q, level_prev_q;
  logic                rise;

  assign shreg_d = {shreg_q[FILT_LEN-2:0], sync2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      shreg_q      <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= pb_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      if (tick_i) begin
        shreg_q <= shreg_d;
        // Decide on the updated window so the level moves the cycle after the tick.
        if (&shreg_d)
          level_q <= 1'b1;
        else if (~|shreg_d)
          level_q <= 1'b0;
      end
    end
  end

  assign rise    = level_q & ~level_prev_q;
  assign level_o = level_q;

`ifdef AUTO_REPEAT_EN
  logic [7:0] hold_q;
  logic       rep_q;

  // After the first repeat the counter is rewound so it only ever spans REP_NEXT ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!level_q) begin
        hold_q <= '0;
      end else if (tick_i) begin
        if (hold_q == 8'(REP_FIRST - 1)) begin
          hold_q <= 8'(REP_FIRST - REP_NEXT);
          rep_q  <= 1'b1;
        end else begin
          hold_q <= hold_q + 8'd1;
        end
      end
    end
  end

  assign evt_o = rise | rep_q;
`else
  assign evt_o = rise;
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces N pushbuttons and round-robins their presses onto one valid/ready port.
// Optional AUTO_REPEAT_EN makes held buttons re-request periodically.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = 1000000,
  parameter int ID_W     = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pb,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)
      tick_cnt_q <= '0;
    else if (tick)
      tick_cnt_q <= '0;
    else
      tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  logic [N_BTN-1:0] edge_evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_filt
    btn_filter u_filt (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (tick),
      .pb_i    (pb[i]),
      .level_o (btn_level[i]),
      .evt_o   (edge_evt[i])
    );
  end

  arb_state_e       state_q;
  logic [N_BTN-1:0] pending_q;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  idx_l;
  logic             found;
  logic             grant_en;
  logic [N_BTN-1:0] grant_mask;
  int               idx;

  // Rotating scan starting just after the previous winner.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    idx   = 0;
    idx_l = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_BTN)
        idx = idx - N_BTN;
      idx_l = ID_W'(idx);
      if (!found && pending_q[idx_l]) begin
        found = 1'b1;
        pick  = idx_l;
      end
    end
  end

  assign grant_en   = (pending_q != '0) && ((state_q == IDLE) || evt_ready);
  assign grant_mask = grant_en ? (N_BTN'(1) << pick) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      last_grant_q <= ID_W'(N_BTN - 1);
      pending_q    <= '0;
      evt_overrun  <= 1'b0;
    end else begin
      // A new press on the bit being granted this cycle survives the clear.
      pending_q <= (pending_q & ~grant_mask) | edge_evt;
      if (|(edge_evt & pending_q & ~grant_mask))
        evt_overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            evt_id       <= pick;
            evt_valid    <= 1'b1;
            last_grant_q <= pick;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (evt_ready) begin
            if (grant_en) begin
              evt_id       <= pick;
              last_grant_q <= pick;
            end else begin
              evt_valid <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: cycle model of debounce/arbitration rules plus directed scenarios.
module tb_btn_event_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  pb = '0;
  logic          evt_ready = 1'b0;
  logic [N-1:0]  btn_level;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_overrun;

  always #5 clk = ~clk;

  btn_event_arbiter #(.N_BTN(N), .TICK_DIV(TD), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pb          (pb),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .evt_overrun (evt_overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run-length debounce, pending set, rotating priority.
  bit m_on = 1'b0;
  int m_cyc;
  bit m_s1[N], m_s2[N];
  int m_run1[N], m_run0[N];
  bit m_lvl[N], m_lvlp[N], m_pend[N], m_rep[N];
  int m_held[N];
  bit m_ovr, m_valid;
  int m_id, m_last;

  always @(posedge clk) begin : model
    bit ev[N];
    bit clr[N];
    bit tk;
    bit lvl_old;
    int g;
    int id;
    if (rst) begin
      m_on = 1'b1; m_cyc = 0; m_ovr = 0; m_valid = 0; m_id = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_run1[i] = 0; m_run0[i] = 4;
        m_lvl[i] = 0; m_lvlp[i] = 0; m_pend[i] = 0; m_rep[i] = 0; m_held[i] = 0;
      end
    end else begin
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      for (int i = 0; i < N; i++) begin
        ev[i]  = (m_lvl[i] && !m_lvlp[i]) || m_rep[i];
        clr[i] = 0;
      end
      g = -1;
      if (!m_valid || evt_ready) begin
        for (int k = 1; k <= N; k++) begin
          id = (m_last + k) % N;
          if (g < 0 && m_pend[id]) g = id;
        end
      end
      if (g >= 0) begin
        clr[g] = 1; m_valid = 1; m_id = g; m_last = g;
      end else if (m_valid && evt_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (ev[i] && m_pend[i] && !clr[i]) m_ovr = 1;
        m_pend[i] = (m_pend[i] && !clr[i]) || ev[i];
      end
      for (int i = 0; i < N; i++) begin
        lvl_old  = m_lvl[i];
        m_lvlp[i] = m_lvl[i];
        if (tk) begin
          if (m_s2[i]) begin m_run1[i]++; m_run0[i] = 0; end
          else         begin m_run0[i]++; m_run1[i] = 0; end
          if (m_run1[i] >= 4)      m_lvl[i] = 1;
          else if (m_run0[i] >= 4) m_lvl[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = pb[i];
        m_rep[i] = 0;
        if (!lvl_old) m_held[i] = 0;
        else if (tk) begin
          m_held[i]++;
`ifdef AUTO_REPEAT_EN
          if (m_held[i] >= 50 && ((m_held[i] - 50) % 10) == 0) m_rep[i] = 1;
`endif
        end
      end
    end
  end

  function automatic int model_levels();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_lvl[i]) v |= (1 << i);
    return v;
  endfunction

  bit last_valid = 1'b0;
  int last_id = 0;
  int acc_ids[$];

  always begin : compare
    @(posedge clk);
    #1;
    if (m_on) begin
      if (!rst && last_valid && evt_ready) acc_ids.push_back(last_id);
      chk("btn_level", int'(btn_level), model_levels());
      chk("evt_valid", int'(evt_valid), int'(m_valid));
      chk("evt_id", int'(evt_id), m_id);
      chk("evt_overrun", int'(evt_overrun), int'(m_ovr));
    end
    last_valid = evt_valid;
    last_id    = int'(evt_id);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int t = 0;
    while (!evt_valid && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, int'(evt_valid), 1);
  endtask

  function automatic int count_id(input int from, input int id);
    int c = 0;
    for (int i = from; i < acc_ids.size(); i++) if (acc_ids[i] == id) c++;
    return c;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int n0;
    int exp_rep;
    rst = 1; pb = '0; evt_ready = 0;
    cyc(3);
    rst = 0;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_valid", int'(evt_valid), 0);
    chk("reset_id", int'(evt_id), 0);
    chk("reset_overrun", int'(evt_overrun), 0);

    // Single bouncy press of button 2
    evt_ready = 1;
    n0 = acc_ids.size();
    repeat (3) begin pb[2] = 1; cyc(2); pb[2] = 0; cyc(2); end
    pb[2] = 1;
    chk("bounce_level_low", int'(btn_level[2]), 0);
    cyc(40);
    chk("press_level_high", int'(btn_level[2]), 1);
    pb[2] = 0;
    cyc(30);
    chk("single_count", acc_ids.size() - n0, 1);
    if (acc_ids.size() > n0) chk("single_id", acc_ids[n0], 2);

    // Round-robin from reset priority
    rst = 1; cyc(1); rst = 0;
    evt_ready = 1;
    n0 = acc_ids.size();
    pb = 4'b1011; cyc(40); pb = '0; cyc(30);
    chk("rr_count", acc_ids.size() - n0, 3);
    if (acc_ids.size() >= n0 + 3) begin
      chk("rr_first", acc_ids[n0], 0);
      chk("rr_second", acc_ids[n0+1], 1);
      chk("rr_third", acc_ids[n0+2], 3);
    end
    n0 = acc_ids.size();
    pb = 4'b1001; cyc(40); pb = '0; cyc(30);
    chk("rr2_count", acc_ids.size() - n0, 2);
    if (acc_ids.size() >= n0 + 2) begin
      chk("rr2_first", acc_ids[n0], 0);
      chk("rr2_second", acc_ids[n0+1], 3);
    end

    // Backpressure
    evt_ready = 0;
    pb[2] = 1;
    wait_valid(80, "bp_wait_valid");
    pb[2] = 0;
    n0 = acc_ids.size();
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", int'(evt_valid), 1);
      chk("bp_hold_id", int'(evt_id), 2);
      cyc(1);
    end
    evt_ready = 1; cyc(1); evt_ready = 0;
    cyc(3);
    chk("bp_one_accept", acc_ids.size() - n0, 1);
    chk("bp_valid_drop", int'(evt_valid), 0);
    cyc(30);

    // Overrun: button 0 occupies the port while button 1 is pressed twice
    evt_ready = 0;
    pb[0] = 1;
    wait_valid(80, "ovr_wait_valid");
    pb[1] = 1; cyc(30);
    pb[1] = 0; cyc(30);
    pb[1] = 1; cyc(30);
    chk("ovr_flag", int'(evt_overrun), 1);
    pb = '0;
    n0 = acc_ids.size();
    evt_ready = 1;
    cyc(40);
    chk("ovr_btn1_events", count_id(n0, 1), 1);
    chk("ovr_total_events", acc_ids.size() - n0, 2);

    // Reset while holding an event
    evt_ready = 0;
    pb[2] = 1;
    wait_valid(80, "rst_wait_valid");
    pb = '0;
    rst = 1; cyc(1); rst = 0;
    chk("rst_hold_valid", int'(evt_valid), 0);
    chk("rst_hold_overrun", int'(evt_overrun), 0);
    cyc(2);
    chk("rst_no_pending", int'(evt_valid), 0);
    evt_ready = 1;
    n0 = acc_ids.size();
    pb = 4'b0101; cyc(40); pb = '0; cyc(30);
    if (acc_ids.size() > n0) chk("rst_first_grant", acc_ids[n0], 0);
    chk("rst_after_count", acc_ids.size() - n0, 2);

    // Long hold: repeats only with the optional feature
    evt_ready = 1;
    n0 = acc_ids.size();
    pb[3] = 1; cyc(300); pb[3] = 0; cyc(40);
`ifdef AUTO_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    chk("hold_events", count_id(n0, 3), exp_rep);

    // Randomized traffic against the model
    begin
      logic [N-1:0] tgt;
      tgt = '0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 15) == 0) tgt[$urandom_range(0, N-1)] ^= 1'b1;
        for (int i = 0; i < N; i++)
          pb[i] = ($urandom_range(0, 7) == 0) ? ~tgt[i] : tgt[i];
        evt_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 999) == 0);
        cyc(1);
      end
      rst = 0; pb = '0; evt_ready = 1;
      cyc(60);
    end
    chk("final_idle", int'(evt_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Controller that shares one event channel between N pushbuttons on the board.
- Generates its own debounce sample tick from the system clock and filters each raw button.
- Turns each debounced press into a one-shot pending request.
- Round-robin arbitrates pending requests onto a single valid/ready event port consumed by downstream FSMs (counters, display control).

Parameters:
- N_BTN, 4, number of pushbuttons; legal range 2..16.
- TICK_DIV, 1000000, system clocks per sample tick (100 MHz -> 100 Hz); must be >= 1.
- ID_W, $clog2(N_BTN), width of the event index.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pb  in  N_BTN  raw asynchronous button levels; double-flop synchronised inside.
- btn_level  out  N_BTN  debounced button levels.
- evt_valid  out  1  event available.
- evt_id  out  ID_W  index of the pressed button; stable while evt_valid=1 and evt_ready=0.
- evt_ready  in  1  consumer accepts the event.
- evt_overrun  out  1  sticky flag: a press was lost.

Behaviour:
- Reset (sync, rst=1 at a posedge) drives these values:
  - all outputs 0;
  - tick counter 0, filters 0, pending 0;
  - last_grant = N_BTN-1, so button 0 has first priority.
- Reset mid-handshake drops the held event without any ack.
- Tick: counter runs 0..TICK_DIV-1 and wraps to 0. tick=1 for one clk when the count equals TICK_DIV-1. With TICK_DIV=1, tick is always 1.
- Filter, per button, on tick:
  - shift the synchronised pb into a 4-bit shift register;
  - btn_level goes to 1 when the register is 4'b1111 and to 0 when it is 4'b0000; otherwise it holds (hysteresis).
  - btn_level changes only in the cycle after a tick.
- Edge: a 0->1 transition of btn_level sets pending[i] on the next clk. A 1->0 transition does nothing.
- Overrun: if an edge arrives while pending[i] is already 1, set evt_overrun; it stays set until rst.
- Arbiter FSM has two states, IDLE and HOLD.
  - IDLE, pending != 0: pick the first set bit scanning last_grant+1 .. last_grant+N_BTN (mod N_BTN). On the next clk, load evt_id, set evt_valid=1, clear that pending bit, update last_grant, and go to HOLD.
  - IDLE, pending == 0: stay in IDLE.
  - HOLD: evt_valid and evt_id are held constant.
  - HOLD, evt_valid & evt_ready: if other requests are pending, grant the next one in the same clk (back-to-back, evt_valid stays 1 and evt_id changes). Otherwise go to IDLE with evt_valid=0.
- Simultaneous set and clear on the same pending bit in one clk: set wins. The bit remains pending and overrun is not flagged.
- Latency:
  - pb stable at 1 -> btn_level=1 after 4 ticks + 2 clk (synchroniser) + 1 clk.
  - btn_level rise -> pending +1 clk -> evt_valid +1 clk when IDLE.
- evt_ready while evt_valid=0 is ignored.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - A per-button 8-bit hold counter counts ticks while btn_level=1.
  - On reaching 50 ticks (0.5 s), and every 10 ticks after that, it re-sets pending[i] exactly like a new edge, including overrun rules.
  - The counter clears when btn_level=0 and on rst.
- Not defined: no hold counters are synthesised, and only 0->1 edges generate events.

Decomposition:
- Package btn_evt_pkg holds:
  - filter length constant FILT_LEN=4;
  - repeat constants REP_FIRST=50 and REP_NEXT=10;
  - arbiter state enum {IDLE, HOLD}.
- Sub-module btn_filter: one instance per button, generated N_BTN times. It contains the synchroniser, the shift-register filter with hysteresis, the edge pulse output, and the optional repeat counter.
- Tick divider and round-robin arbiter stay in the top level.

Test Plan:
- Single press:
  - Stimulus: TICK_DIV=4, evt_ready=1; pb[2] rises with 3 bounces of 2 clk each, then stays 1 for 40 clk.
  - Required: exactly one event with evt_id=2; btn_level[2] rises only after 4 consecutive 1-samples.
- Round-robin fairness:
  - Stimulus: buttons 0, 1, 3 pressed in the same tick; evt_ready=1.
  - Required: evt_id sequence 0, 1, 3 on consecutive clks. A second simultaneous press of 0 and 3 then yields 3 first? No — it yields 0 then 3, because last_grant=3.
- Backpressure:
  - Stimulus: evt_ready=0 for 20 clk after evt_valid rises.
  - Required: evt_id and evt_valid stay constant. Ready pulsed for 1 clk produces exactly one acceptance.
- Overrun:
  - Stimulus: evt_ready=0; press button 1, release it, press it again.
  - Required: evt_overrun=1. Only one event is delivered for button 1 after ready is raised.
- Reset mid-HOLD:
  - Stimulus: assert rst for 1 clk while evt_valid=1.
  - Required: the next clk shows evt_valid=0, pending=0 and evt_overrun=0. A press of button 0 is then granted first.
- AUTO_REPEAT_EN:
  - Stimulus: TICK_DIV=1, hold pb[0] high for 80 ticks with evt_ready=1.
  - Required: events at the press, at +50 ticks, +60 and +70 (4 total). With the macro undefined: 1 event.
